// File: rtl/shift_seq.sv
// Sequential 32-bit barrel shifter: sll or sra, applied as five fixed stages
// (16, 8, 4, 2, 1) over five cycles, with valid/ready on both sides.
module shift_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        dir,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        ovf,
    output logic        busy
);

    // Handshake: a request moves on a rising edge with in_valid && in_ready;
    // a result is consumed on a rising edge in DONE with out_ready (out_valid is 1 there).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] work;
    logic [4:0]  amt_q;
    logic        dir_q;
    logic [2:0]  stage;

    logic [4:0]  step_amt;
    logic        step_en;
    logic [63:0] sll_wide;
    logic [31:0] sra_val;

    always_comb begin
        step_amt = 5'd0;
        step_en  = 1'b0;
        case (stage)
            3'd0: begin step_amt = 5'd16; step_en = amt_q[4]; end
            3'd1: begin step_amt = 5'd8;  step_en = amt_q[3]; end
            3'd2: begin step_amt = 5'd4;  step_en = amt_q[2]; end
            3'd3: begin step_amt = 5'd2;  step_en = amt_q[1]; end
            3'd4: begin step_amt = 5'd1;  step_en = amt_q[0]; end
            default: begin step_amt = 5'd0; step_en = 1'b0; end
        endcase
    end

    // Upper half of the widened shift holds exactly the bits pushed past bit 31.
    assign sll_wide = {32'd0, work} << step_amt;
    assign sra_val  = $signed(work) >>> step_amt;

    assign data_out = work;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            work      <= 32'd0;
            amt_q     <= 5'd0;
            dir_q     <= 1'b0;
            stage     <= 3'd0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= data_in;
                        amt_q    <= shamt;
                        dir_q    <= dir;
                        ovf      <= 1'b0;
                        stage    <= 3'd0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (step_en) begin
                        if (dir_q) begin
                            work <= sra_val;
                        end else begin
                            work <= sll_wide[31:0];
                            ovf  <= ovf | (|sll_wide[63:32]);
                        end
                    end
                    stage <= stage + 3'd1;
                    if (stage == 3'd4) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed vector table, backpressure/isolation/reset
// sequences, and random requests checked against a whole-shift reference model.
module tb_shift_seq;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        dir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        ovf;
    logic        busy;

    shift_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // {ovf, data} expected per accepted request
    logic [32:0] exp_q[$];

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        dr;
        logic [31:0] exp_d;
        logic        exp_o;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole shift in one step; ovf is "any 1 among the top s bits".
    function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] s, input logic dr);
        logic [31:0] r;
        logic        o;
        if (dr) begin
            r = $unsigned($signed(d) >>> s);
            o = 1'b0;
        end else begin
            r = d << s;
            o = (s == 5'd0) ? 1'b0 : ((d >> (6'd32 - {1'b0, s})) != 32'd0);
        end
        return {o, r};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (in_ready !== 1'b1) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic dr,
                        input int stall, input bit scramble, input bit hold_valid);
        int          lat;
        logic [32:0] exp;
        logic [31:0] held_d;
        logic        held_o;
        @(negedge clock);
        wait_ready();
        in_valid = 1'b1;
        data_in  = d;
        shamt    = s;
        dir      = dr;
        exp_q.push_back(model(d, s, dr));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            if (scramble) begin
                data_in  = $urandom;
                shamt    = 5'($urandom_range(0, 31));
                dir      = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
            end
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            lat++;
            if (out_valid === 1'b1) break;
        end
        in_valid = 1'b0;
        chk("latency", lat, 32'd5);
        exp = exp_q.pop_front();
        chk("data_out", data_out, exp[31:0]);
        chk("ovf", {31'd0, ovf}, {31'd0, exp[32]});
        held_d = data_out;
        held_o = ovf;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (hold_valid) begin
                in_valid = 1'b1;
                data_in  = $urandom;
            end
            @(posedge clock);
            #1;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", data_out, held_d);
            chk("stall_ovf", {31'd0, ovf}, {31'd0, held_o});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        if (hold_valid) in_valid = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_busy", {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b0};
        vecs[1] = '{32'h8000_0000, 5'd16, 1'b1, 32'hFFFF_8000, 1'b0};
        vecs[2] = '{32'h7FFF_0000, 5'd31, 1'b1, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 5'd0,  1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{32'h1234_5678, 5'd4,  1'b0, 32'h2345_6780, 1'b1};
        vecs[5] = '{32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002, 1'b1};
        vecs[6] = '{32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000, 1'b0};
        vecs[7] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{32'hFFFF_FFFF, 5'd0,  1'b1, 32'hFFFF_FFFF, 1'b0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        data_in   = 32'd0;
        shamt     = 5'd0;
        dir       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed table: expectations are hand-derived constants
        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].exp_o, vecs[i].exp_d});
            send(vecs[i].d, vecs[i].s, vecs[i].dr, 0, 1'b0, 1'b0);
            // send() queued the model's value too; the constant must agree with it
            chk("table_vs_model", exp_q.pop_front(), {vecs[i].exp_o, vecs[i].exp_d});
        end

        // Backpressure for 10 cycles with in_valid held high, then back-to-back
        send(32'h1234_5678, 5'd4, 1'b0, 10, 1'b0, 1'b1);
        send(32'h0000_00FF, 5'd8, 1'b0, 0, 1'b0, 1'b0);

        // Inputs toggling every cycle during SHIFT
        send(32'hC3A5_0F01, 5'd13, 1'b1, 2, 1'b1, 1'b0);
        send(32'hC3A5_0F01, 5'd13, 1'b0, 1, 1'b1, 1'b0);

        // Reset at stage index 2
        @(negedge clock);
        wait_ready();
        in_valid = 1'b1;
        data_in  = 32'hDEAD_BEEF;
        shamt    = 5'd0;
        dir      = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
        end
        send(32'h0000_0003, 5'd30, 1'b0, 0, 1'b0, 1'b0);

        // Random requests with random stalls
        for (int n = 0; n < 1000; n++) begin
            send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
